// File: rtl/mem_interface_unit.sv
// Memory-side responder for instruction-unit load/store requests: byte loads and
// two-beat 16-bit stores over a byte-wide req/ack memory port with a per-beat timeout.
module mem_interface_unit #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       result,
    output logic [7:0]        data,
    output logic              mem_done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] WR_LO   = 3'd2;
    localparam logic [2:0] WR_HI   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] RELEASE = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       res_hi;
    logic             beat_ack;
    logic             beat_to;
    logic             accept;

    assign accept   = (state == IDLE) && (load ^ store);
    assign beat_ack = mem_req && mem_ack;
    // The last wait cycle of a beat is the one where the count reaches TIMEOUT-1.
    assign beat_to  = !beat_ack && (cnt == CNT_W'(TIMEOUT - 1));

    // High store byte is only consumed after the low beat, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            res_hi <= result[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            data      <= 8'h00;
            mem_done  <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cnt       <= '0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        err       <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= store;
                        mem_addr  <= addr;
                        mem_wdata <= result[7:0];
                        cnt       <= '0;
                        state     <= load ? RD : WR_LO;
                    end else if (load && store) begin
                        err      <= 1'b1;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                RD: begin
                    if (beat_ack) begin
                        data     <= mem_rdata;
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else if (beat_to) begin
                        data     <= 8'hFF;
                        err      <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_LO: begin
                    // Back-to-back beat: req stays high, address/data advance.
                    if (beat_ack) begin
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= res_hi;
                        cnt       <= '0;
                        state     <= WR_HI;
                    end else if (beat_to) begin
                        err      <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_HI: begin
                    if (beat_ack || beat_to) begin
                        err      <= beat_to;
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A still-held level request must not retrigger a transfer.
                    if (!load && !store) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: vector table of transactions against a
// simple memory responder, plus hand-written reset sequences.
module tb_mem_interface_unit;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 16;
    localparam int WINDOW  = 26;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load = 1'b0;
    logic              store = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [15:0]       result = '0;
    logic [7:0]        data;
    logic              mem_done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic              mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_interface_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
        .result(result), .data(data), .mem_done(mem_done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [13:0] a;
        logic [15:0] res;
        logic [7:0]  rdata;
        int          wt;       // wait cycles before ack, -1 = never ack
        int          hold;     // cycles the request stays high after mem_done
        int          nbeats;
        logic [13:0] a0;
        logic [7:0]  d0;
        logic [13:0] a1;
        logic [7:0]  d1;
        logic        we;
        int          done_cyc;
        int          reqcyc;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          done_cyc = 0;
        int          done_cnt = 0;
        int          reqcyc = 0;
        int          nb = 0;
        int          waited = 0;
        int          unstable = 0;
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic [13:0] prev_addr = '0;
        logic        prev_we = 1'b0;
        logic [7:0]  prev_wd = '0;
        logic [13:0] ba [2];
        logic [7:0]  bd [2];
        logic        bw [2];
        string       tag;
        ba[0] = '0; ba[1] = '0; bd[0] = '0; bd[1] = '0; bw[0] = 1'b0; bw[1] = 1'b0;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        load = v.ld; store = v.st; addr = v.a; result = v.res; mem_ack = 1'b0;
        for (int k = 1; k <= WINDOW; k++) begin
            @(negedge clk);
            if (mem_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (mem_req && prev_req && !prev_ack &&
                (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wd))
                unstable++;
            prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wd = mem_wdata;
            if (mem_req) begin
                reqcyc++;
                if (v.wt >= 0 && waited == v.wt) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                    if (nb < 2) begin
                        ba[nb] = mem_addr; bd[nb] = mem_wdata; bw[nb] = mem_we;
                    end
                    nb++;
                    waited = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 8'h00;
                    waited++;
                end
            end else begin
                mem_ack = 1'b0;
                waited = 0;
            end
            prev_ack = mem_ack;
            if (done_cyc > 0 && k >= done_cyc + v.hold) begin
                load = 1'b0; store = 1'b0;
            end
        end
        mem_ack = 1'b0;
        chk({tag, " done_cycle"}, done_cyc, v.done_cyc);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " req_cycles"}, reqcyc, v.reqcyc);
        chk({tag, " beats"}, nb, v.nbeats);
        chk({tag, " unstable"}, unstable, 0);
        chk({tag, " data"}, data, v.exp_data);
        chk({tag, " err"}, err, v.exp_err);
        if (v.nbeats >= 1) begin
            chk({tag, " beat0_addr"}, ba[0], v.a0);
            chk({tag, " beat0_we"}, bw[0], v.we);
            if (v.we) chk({tag, " beat0_wdata"}, bd[0], v.d0);
        end
        if (v.nbeats >= 2) begin
            chk({tag, " beat1_addr"}, ba[1], v.a1);
            chk({tag, " beat1_we"}, bw[1], v.we);
            chk({tag, " beat1_wdata"}, bd[1], v.d1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_req"}, mem_req, 1'b0);
        chk({tag, " mem_we"}, mem_we, 1'b0);
        chk({tag, " mem_addr"}, mem_addr, '0);
        chk({tag, " mem_wdata"}, mem_wdata, 8'h00);
        chk({tag, " data"}, data, 8'h00);
        chk({tag, " err"}, err, 1'b0);
        chk({tag, " mem_done"}, mem_done, 1'b0);
    endtask

    vec_t vecs [8];
    vec_t post;

    initial begin
        int extra_done;
        int extra_req;
        //          ld    st    addr      result    rdata  wt hold nb a0        d0     a1        d1     we    dc  rq  data   err
        vecs[0] = '{1'b1, 1'b0, 14'h0123, 16'h0000, 8'h5A,  0, 0, 1, 14'h0123, 8'h00, 14'h0000, 8'h00, 1'b0,  2,  1, 8'h5A, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 14'h0010, 16'hBEEF, 8'h00,  2, 0, 2, 14'h0010, 8'hEF, 14'h0011, 8'hBE, 1'b1,  7,  6, 8'h5A, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 14'h3FFF, 16'h1234, 8'h00,  0, 0, 2, 14'h3FFF, 8'h34, 14'h0000, 8'h12, 1'b1,  3,  2, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 14'h0200, 16'h0000, 8'h00, -1, 0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 1'b0, 17, 16, 8'hFF, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 14'h0201, 16'h0000, 8'h3C,  1, 0, 1, 14'h0201, 8'h00, 14'h0000, 8'h00, 1'b0,  3,  2, 8'h3C, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 14'h0300, 16'hAAAA, 8'h00,  0, 0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 1'b0,  1,  0, 8'h3C, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 14'h0005, 16'h0000, 8'hA7,  0, 5, 1, 14'h0005, 8'h00, 14'h0000, 8'h00, 1'b0,  2,  1, 8'hA7, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 14'h0400, 16'h5566, 8'h00, -1, 0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 1'b0, 17, 16, 8'hA7, 1'b1};
        post    = '{1'b1, 1'b0, 14'h1ABC, 16'h0000, 8'h99,  0, 0, 1, 14'h1ABC, 8'h00, 14'h0000, 8'h00, 1'b0,  2,  1, 8'h99, 1'b0};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while the high store beat is waiting for its ack.
        @(negedge clk);
        store = 1'b1; addr = 14'h0040; result = 16'hC0DE;
        @(negedge clk);
        chk("rst_seq wr_lo_req", mem_req, 1'b1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_seq wr_hi_addr", mem_addr, 14'h0041);
        chk("rst_seq wr_hi_wdata", mem_wdata, 8'hC0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        store = 1'b0;
        extra_done = 0; extra_req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_done) extra_done++;
            if (mem_req) extra_req++;
        end
        chk("midreset no_done", extra_done, 0);
        chk("midreset no_req", extra_req, 0);
        run_vec(8, post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
